// File: rtl/cordic_pkg.sv
// Purpose: shared types and constants for the CORDIC result credit buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cordic_pkg;
   // Q4.8 result: 4 integer bits (sign included) and 8 fractional bits.
   localparam int CORDIC_VALUE_WIDTH = 12;
   localparam int CORDIC_FRAC_BITS   = 8;
   localparam int CORDIC_ID_WIDTH    = 8;

   typedef logic signed [CORDIC_VALUE_WIDTH-1:0] value_t;
endpackage

// File: rtl/cordic_credit_buffer_if.sv
// Purpose: issue credit, pipeline result and consumer handshake bundle.
// Latency: n/a (wires only).
// Backpressure: only the out_valid/out_ready leg can stall; results cannot.
interface cordic_credit_buffer_if
   import cordic_pkg::*;
#(
   parameter int ID_WIDTH    = CORDIC_ID_WIDTH,
   parameter int VALUE_WIDTH = CORDIC_VALUE_WIDTH
) ();
   logic                          issue_req;
   logic                          issue_gnt;
   logic                          in_valid;
   logic signed [VALUE_WIDTH-1:0] in_value;
   logic [ID_WIDTH-1:0]           in_id;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [VALUE_WIDTH-1:0] out_value;
   logic [ID_WIDTH-1:0]           out_id;

   // Upstream issuer, pipeline output and ray consumer as seen from outside.
   modport master (
      output issue_req, input issue_gnt,
      output in_valid, output in_value, output in_id,
      input out_valid, output out_ready, input out_value, input out_id
   );

   // The buffer itself.
   modport slave (
      input issue_req, output issue_gnt,
      input in_valid, input in_value, input in_id,
      output out_valid, input out_ready, output out_value, output out_id
   );
endinterface

// File: rtl/cordic_buf_mem.sv
// Purpose: DEPTH x WIDTH storage, one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after wr_en.
// Backpressure: none; the caller decides when writes happen.
module cordic_buf_mem
   import cordic_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = CORDIC_VALUE_WIDTH + CORDIC_ID_WIDTH
) (
   input  logic                     clock,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Storage carries no reset; validity is tracked by the level counter.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/cordic_credit_buffer.sv
// Purpose: credit-gated output FIFO behind the fixed-latency CORDIC pipeline (optional tag check: CORDIC_BUF_ID_CHECK_EN).
// Latency: in_valid -> out_valid 1 cycle, FWFT head, no bypass.
// Backpressure: results are never stalled; issue_gnt withholds credit so every in-flight op has a slot.
module cordic_credit_buffer
   import cordic_pkg::*;
#(
   parameter int ID_WIDTH    = CORDIC_ID_WIDTH,
   parameter int VALUE_WIDTH = CORDIC_VALUE_WIDTH,
   parameter int DEPTH       = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   cordic_credit_buffer_if.slave  bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   proto_err,
   output logic                   id_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_L   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   inflight;
   logic [AW+1:0] committed;
   logic          full, empty, pop, push, stray, ret, gnt;
   logic [ID_WIDTH+VALUE_WIDTH-1:0] rd_data;

   // Credits come from registered state only: a pop frees a slot for the next cycle, never this one.
   assign committed = {1'b0, level} + {1'b0, inflight};
   assign gnt       = !reset && bus.issue_req && (committed < (AW+2)'(DEPTH));
   assign bus.issue_gnt = gnt;

   assign full  = (level == DEPTH_L);
   assign empty = (level == '0);
   assign pop   = !empty && bus.out_ready;
   // A full buffer can still take a result when the head leaves in the same cycle.
   assign push  = bus.in_valid && (!full || pop);
   // A result with nothing in flight is a protocol fault; it is still stored but returns no credit.
   assign stray = bus.in_valid && (inflight == '0);
   assign ret   = bus.in_valid && !stray;

   cordic_buf_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ID_WIDTH + VALUE_WIDTH)
   ) u_mem (
      .clock   (clock),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({bus.in_id, bus.in_value}),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   assign bus.out_valid = !empty;
   assign bus.out_value = empty ? '0 : rd_data[VALUE_WIDTH-1:0];
   assign bus.out_id    = empty ? '0 : rd_data[ID_WIDTH+VALUE_WIDTH-1:VALUE_WIDTH];

   // Pointer, occupancy, credit and sticky protocol-fault bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         inflight  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + ONE_L;
            2'b01:   level <= level - ONE_L;
            default: level <= level;
         endcase
         case ({gnt, ret})
            2'b10:   inflight <= inflight + ONE_L;
            2'b01:   inflight <= inflight - ONE_L;
            default: inflight <= inflight;
         endcase
         if (stray || (bus.in_valid && full && !pop)) proto_err <= 1'b1;
      end
   end

`ifdef CORDIC_BUF_ID_CHECK_EN
   logic [ID_WIDTH-1:0] exp_id;

   // Results must come back in issue order; every arriving result advances the expected tag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         exp_id <= '0;
         id_err <= 1'b0;
      end else if (bus.in_valid) begin
         exp_id <= exp_id + ID_WIDTH'(1);
         if (bus.in_id != exp_id) id_err <= 1'b1;
      end
   end
`else
   assign id_err = 1'b0;
`endif
endmodule
